// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and width limits.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int WIDTH_MIN = 2;

   // Bit-counter width; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w <= WIDTH_MIN) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder used as the datapath of the bit-serial adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, one bit per clock LSB-first through a single fa_cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q, cout_q, busy_q, done_q;
   logic [WIDTH-1:0] sum_d, b_load_d;
   logic             carry_seed_d;
   logic             fa_sum, fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q;
`endif

   fa_cell u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Subtraction is a + ~b + 1, so the carry seed replaces cin with 1.
   assign b_load_d     = sub ? ~b : b;
   assign carry_seed_d = sub ? 1'b1 : cin;
   assign sum_d        = {fa_sum, sum_q[WIDTH-1:1]};

   // NOTE: every flop, including the operand shift registers, uses <= so all
   // state updates see pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  a_q     <= a;
                  b_q     <= b_load_d;
                  carry_q <= carry_seed_d;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               sum_q   <= sum_d;
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= fa_cout;
               if (cnt_q == LAST) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cout_q  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf_q   <= carry_q ^ fa_cout;
`endif
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random ops vs. an arithmetic model.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start, cin, sub;
   logic [W-1:0] a, b, sum;
   logic         busy, done, cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain unsigned/signed arithmetic, returns {ovf, cout, sum}.
   function automatic logic [W+1:0] model(input logic [W-1:0] av, bv, input logic ci, sb);
      longint ua = av;
      longint ub = bv;
      longint sa = $signed(av);
      longint sbv = $signed(bv);
      longint r, s;
      logic   c, v;
      if (sb) begin
         r = ua - ub;
         c = (ua >= ub);
         s = sa - sbv;
      end else begin
         r = ua + ub + longint'(ci);
         c = (r >= (longint'(1) << W));
         s = sa + sbv + longint'(ci);
      end
      v = (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
      return {v, c, r[W-1:0]};
   endfunction

   task automatic launch(input bit wait_edge, input logic [W-1:0] av, bv, input logic ci, sb);
      if (wait_edge) @(negedge clk);
      a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
   endtask

   // Follows an op from the cycle after start was sampled through done.
   // inj: RUN cycle in which a stray start is driven (0 = none).
   // chain: drive a new start in the done cycle with operands na/nb.
   task automatic finish(input string tag, input logic [W-1:0] es, input logic ec, eo,
                         input int inj, input bit chain, input logic [W-1:0] na, nb);
      int lat;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      check({tag, ":busy_first"}, busy, 1);
      check({tag, ":done_first"}, done, 0);
      while (done !== 1'b1 && lat < 4 * W) begin
         if (lat == inj) begin
            start = 1'b1; a = 8'hAA; b = 8'h55;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      check({tag, ":latency"}, lat, W + 1);
      check({tag, ":busy_at_done"}, busy, 0);
      check({tag, ":sum"}, sum, es);
      check({tag, ":cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, ":ovf"}, ovf, eo);
`endif
      if (chain) begin
         a = na; b = nb; cin = 1'b0; sub = 1'b0; start = 1'b1;
      end else begin
         @(negedge clk);
         check({tag, ":done_pulse"}, done, 0);
         check({tag, ":busy_idle"}, busy, 0);
         check({tag, ":sum_hold"}, sum, es);
         check({tag, ":cout_hold"}, cout, ec);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W+1:0] exp_r;
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      int           done_cnt;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      check("reset:busy", busy, 0);
      check("reset:done", done, 0);
      check("reset:sum", sum, 0);
      check("reset:cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
      check("reset:ovf", ovf, 0);
`endif
      rst = 1'b0;

      launch(1, 8'h3C, 8'h45, 1'b0, 1'b0);
      finish("add_3c_45", 8'h81, 1'b0, 1'b1, 0, 0, 8'h00, 8'h00);

      launch(1, 8'hFF, 8'h01, 1'b1, 1'b0);
      finish("add_ff_01_cin", 8'h01, 1'b1, 1'b0, 0, 0, 8'h00, 8'h00);

      launch(1, 8'h10, 8'h20, 1'b1, 1'b1);
      finish("sub_10_20", 8'hF0, 1'b0, 1'b0, 0, 0, 8'h00, 8'h00);

      launch(1, 8'h01, 8'h01, 1'b0, 1'b0);
      finish("start_in_run", 8'h02, 1'b0, 1'b0, 3, 0, 8'h00, 8'h00);

      // Reset in RUN cycle 4: immediate abort, no done pulse afterwards.
      launch(1, 8'h01, 8'h01, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrun_rst:busy", busy, 0);
      check("midrun_rst:sum", sum, 0);
      check("midrun_rst:done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      check("midrun_rst:no_done", done_cnt, 0);
      launch(1, 8'h7F, 8'h01, 1'b0, 1'b0);
      finish("after_rst_7f_01", 8'h80, 1'b0, 1'b1, 0, 0, 8'h00, 8'h00);

      // Back-to-back: start held in the done cycle.
      launch(1, 8'h11, 8'h22, 1'b0, 1'b0);
      finish("chain_first", 8'h33, 1'b0, 1'b0, 0, 1, 8'h02, 8'h03);
      finish("chain_second", 8'h05, 1'b0, 1'b0, 0, 0, 8'h00, 8'h00);

      for (int n = 0; n < 20; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         exp_r = model(ra, rb, rc, rs);
         launch(1, ra, rb, rc, rs);
         finish($sformatf("rand%0d", n), exp_r[W-1:0], exp_r[W], exp_r[W+1], 0, 0, 8'h00, 8'h00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
